// File: rtl/jt10_adpcm_mch_pkg.sv
// jt10_adpcm_pkg: shared constants and helpers for the multichannel
// ADPCM-A decoder.
//   SW            step register width
//   STEP_MIN_DEF  default lower step clamp, also the reset/restart step
//   STEP_MAX_DEF  default upper step clamp
//   step_mul()    step adaptation multiplier selected by nibble magnitude
package jt10_adpcm_pkg;

   localparam int SW           = 15;
   localparam int STEP_MIN_DEF = 127;
   localparam int STEP_MAX_DEF = 24576;

   function automatic logic [7:0] step_mul(input logic [2:0] mag);
      logic [7:0] m;
      case (mag)
         3'd4:    m = 8'd77;
         3'd5:    m = 8'd102;
         3'd6:    m = 8'd128;
         3'd7:    m = 8'd153;
         default: m = 8'd57;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/jt10_adpcm_mch_if.sv
// jt10_adpcm_mch_if: nibble input handshake and decoded sample output.
//   in_valid/in_ready/in_ch/data/chon/kon  sequencer -> decoder
//   out_valid/out_ch/pcm                   decoder -> mixer
// master = sequencer/mixer side, slave = decoder side.
interface jt10_adpcm_mch_if #(
   parameter int NCH = 6,
   parameter int DW  = 16
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic                  in_valid;
   logic                  in_ready;
   logic [CHW-1:0]        in_ch;
   logic [3:0]            data;
   logic                  chon;
   logic                  kon;
   logic                  out_valid;
   logic [CHW-1:0]        out_ch;
   logic signed [DW-1:0]  pcm;

   modport master (
      output in_valid, in_ch, data, chon, kon,
      input  in_ready, out_valid, out_ch, pcm
   );

   modport slave (
      input  in_valid, in_ch, data, chon, kon,
      output in_ready, out_valid, out_ch, pcm
   );
endinterface

// File: rtl/jt10_adpcm_mch_ram.sv
// jt10_adpcm_mch_ram: NCH-entry register file holding {x, step} per channel.
//   clk, rst_n         clock, async active-low reset (x=0, step=STEP_MIN)
//   rd_addr            read port address (combinational read)
//   rd_x, rd_step      read data
//   we                 write enable (already qualified by clock enable)
//   wr_addr            write port address
//   wr_x, wr_step      write data
module jt10_adpcm_mch_ram
   import jt10_adpcm_pkg::*;
#(
   parameter int NCH      = 6,
   parameter int DW       = 16,
   parameter int STEP_MIN = STEP_MIN_DEF,
   parameter int CHW      = 3
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CHW-1:0]       rd_addr,
   output logic signed [DW-1:0] rd_x,
   output logic [SW-1:0]        rd_step,
   input  logic                 we,
   input  logic [CHW-1:0]       wr_addr,
   input  logic signed [DW-1:0] wr_x,
   input  logic [SW-1:0]        wr_step
);

   logic signed [DW-1:0] x_mem    [NCH];
   logic [SW-1:0]        step_mem [NCH];

   // Out-of-range addresses read as zero; they are never accepted anyway.
   always_comb begin
      rd_x    = '0;
      rd_step = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (rd_addr == CHW'(i)) begin
            rd_x    = x_mem[i];
            rd_step = step_mem[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            x_mem[i]    <= '0;
            step_mem[i] <= SW'(STEP_MIN);
         end
      end else if (we) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (wr_addr == CHW'(i)) begin
               x_mem[i]    <= wr_x;
               step_mem[i] <= wr_step;
            end
         end
      end
   end

endmodule

// File: rtl/jt10_adpcm_mch.sv
// jt10_adpcm_mch: time-multiplexed ADPCM-A nibble decoder for NCH channels.
//   clk, rst_n   clock, async active-low reset
//   cen          clock enable; all state advances only when high
//   bus (slave)  nibble in (valid/ready, channel, data, chon, kon),
//                decoded sample out (out_valid pulse, out_ch, pcm)
// Five-stage pipeline: S1 state fetch, S2 multiply, S3 sign, S4 add,
// S5 saturate/clamp/write-back. A per-channel busy bit blocks re-issue of a
// channel until its write-back, so each accept reads up-to-date state.
module jt10_adpcm_mch
   import jt10_adpcm_pkg::*;
#(
   parameter int NCH      = 6,
   parameter int DW       = 16,
   parameter int STEP_MIN = STEP_MIN_DEF,
   parameter int STEP_MAX = STEP_MAX_DEF
)(
   input logic              clk,
   input logic              rst_n,
   input logic              cen,
   jt10_adpcm_mch_if.slave  bus
);

   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   // Sum width covers the full 16-bit delta plus sign so overflow is seen
   // even when |d| exceeds the DW range.
   localparam int AW = ((DW > 16) ? DW : 16) + 2;
   localparam logic [SW-1:0]        STEP_RST = SW'(STEP_MIN);
   localparam logic signed [AW-1:0] X_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] X_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   logic           accept;
   logic [NCH-1:0] busy;

   always_comb begin
      bus.in_ready = 1'b0;
      if (32'(bus.in_ch) < NCH) bus.in_ready = ~busy[bus.in_ch];
   end

   assign accept = cen & bus.in_valid & bus.in_ready;

   // Stage registers
   logic                 s1_v, s2_v, s3_v, s4_v;
   logic [CHW-1:0]       s1_ch, s2_ch, s3_ch, s4_ch;
   logic                 s1_chon, s2_chon, s3_chon, s4_chon;
   logic [3:0]           s1_data;
   logic                 s2_sign;
   logic signed [DW-1:0] s1_x, s2_x, s3_x;
   logic [SW-1:0]        s1_step;
   logic [15:0]          s2_d;
   logic [16:0]          s2_step, s3_step, s4_step;
   logic signed [AW-1:0] s3_d, s4_sum;

   // RAM ports
   logic signed [DW-1:0] rd_x, wr_x;
   logic [SW-1:0]        rd_step, wr_step;
   logic                 we;

   jt10_adpcm_mch_ram #(
      .NCH      (NCH),
      .DW       (DW),
      .STEP_MIN (STEP_MIN),
      .CHW      (CHW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_addr (bus.in_ch),
      .rd_x    (rd_x),
      .rd_step (rd_step),
      .we      (we),
      .wr_addr (s4_ch),
      .wr_x    (wr_x),
      .wr_step (wr_step)
   );

   // S2 arithmetic
   logic [18:0] d_prod;
   logic [22:0] st_prod;
   always_comb begin
      d_prod  = 19'({s1_data[2:0], 1'b1}) * 19'(s1_step);
      st_prod = 23'(step_mul(s1_data[2:0])) * 23'(s1_step);
   end

   // S5 saturation, clamp and mute
   always_comb begin
      if (s4_sum > X_MAX)      wr_x = X_MAX[DW-1:0];
      else if (s4_sum < X_MIN) wr_x = X_MIN[DW-1:0];
      else                     wr_x = s4_sum[DW-1:0];
      if (s4_step < 17'(STEP_MIN))      wr_step = STEP_RST;
      else if (s4_step > 17'(STEP_MAX)) wr_step = SW'(STEP_MAX);
      else                              wr_step = s4_step[SW-1:0];
      if (!s4_chon) begin
         wr_x    = '0;
         wr_step = STEP_RST;
      end
      we = cen & s4_v;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0; s2_v <= 1'b0; s3_v <= 1'b0; s4_v <= 1'b0;
         s1_ch <= '0; s2_ch <= '0; s3_ch <= '0; s4_ch <= '0;
         s1_chon <= 1'b0; s2_chon <= 1'b0; s3_chon <= 1'b0; s4_chon <= 1'b0;
         s1_data <= '0; s2_sign <= 1'b0;
         s1_x <= '0; s2_x <= '0; s3_x <= '0;
         s1_step <= STEP_RST;
         s2_d <= '0; s2_step <= '0; s3_step <= '0; s4_step <= '0;
         s3_d <= '0; s4_sum <= '0;
      end else if (cen) begin
         // S1
         s1_v <= accept;
         if (accept) begin
            s1_ch   <= bus.in_ch;
            s1_data <= bus.data;
            s1_chon <= bus.chon;
            s1_x    <= bus.kon ? '0 : rd_x;
            s1_step <= bus.kon ? STEP_RST : rd_step;
         end
         // S2
         s2_v    <= s1_v;
         s2_ch   <= s1_ch;
         s2_chon <= s1_chon;
         s2_sign <= s1_data[3];
         s2_x    <= s1_x;
         s2_d    <= d_prod[18:3];
         s2_step <= st_prod[22:6];
         // S3
         s3_v    <= s2_v;
         s3_ch   <= s2_ch;
         s3_chon <= s2_chon;
         s3_x    <= s2_x;
         s3_step <= s2_step;
         s3_d    <= s2_sign ? -$signed(AW'(s2_d)) : $signed(AW'(s2_d));
         // S4
         s4_v    <= s3_v;
         s4_ch   <= s3_ch;
         s4_chon <= s3_chon;
         s4_step <= s3_step;
         s4_sum  <= AW'(s3_x) + s3_d;
      end
   end

   // S5 output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_ch    <= '0;
         bus.pcm       <= '0;
      end else if (cen) begin
         bus.out_valid <= s4_v;
         if (s4_v) begin
            bus.out_ch <= s4_ch;
            bus.pcm    <= wr_x;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else if (cen) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (accept && bus.in_ch == CHW'(i))  busy[i] <= 1'b1;
            else if (s4_v && s4_ch == CHW'(i))   busy[i] <= 1'b0;
         end
      end
   end

endmodule

// File: doc/jt10_adpcm_mch.md
Name: jt10_adpcm_mch

Overview:
Parametrised, time-multiplexed ADPCM-A (YM2610-style) nibble decoder for NCH channels. Channel state (accumulator x, step size) lives in internal per-channel registers. The sequencer presents one nibble per accepted cycle through a valid/ready handshake, and the decoded sample leaves with its channel tag. It sits between the ADPCM-A sample fetch/sequencer and the channel mixer/accumulator. It adds key-on restart, a per-channel in-flight hazard guard and parametrised limits.

Parameters:
NCH, 6, number of channels (1..16); CHW = max(1, clog2(NCH)) is derived.
DW, 16, signed output/accumulator width (12..18).
STEP_MIN, 127, step lower clamp; also the reset and restart step value.
STEP_MAX, 24576, step upper clamp; must fit in SW = 15 bits.

Ports:
clk  in  1  clock
rst_n  in  1  reset: asynchronous, active-low
cen  in  1  clock enable; all state advances only when cen=1
in_valid  in  1  nibble present
in_ready  out  1  channel in_ch may accept
in_ch  in  CHW  channel index
data  in  4  ADPCM nibble: bit3 sign, bits2:0 magnitude
chon  in  1  channel on; 0 forces mute/reset of that channel
kon  in  1  key-on: restart channel state before decoding this nibble
out_valid  out  1  one-cen-cycle pulse, result present
out_ch  out  CHW  channel of result
pcm  out  DW  signed decoded sample

Behaviour:
- Reset: all x[ch]=0, step[ch]=STEP_MIN, busy=0; out_valid=0, out_ch=0, pcm=0; all pipeline valid bits 0.
- Accept = cen & in_valid & in_ready.
- in_ready is combinational: (in_ch < NCH) & ~busy[in_ch]. An out-of-range in_ch is never accepted.
- busy[ch] is set on accept and cleared on that channel's write-back edge.
- Same-channel issue spacing is therefore at least 5 cen cycles. Different channels may issue every cen cycle.
- Pipeline, one stage per cen cycle:
  - S1: latch ch, data, chon and state. If kon=1, the latched state is x=0, step=STEP_MIN; otherwise it is the stored x[ch], step[ch].
  - S2: d = ((2*data[2:0]+1) * step) >> 3, giving an unsigned 16-bit result. step' = (mul * step) >> 6, unsigned 17-bit, with mul by data[2:0]: 0-3 -> 57, 4 -> 77, 5 -> 102, 6 -> 128, 7 -> 153.
  - S3: negate d if data[3]=1. Record signEqu = (data[3] == x[DW-1]).
  - S4: x' = x + d, computed at DW bits.
  - S5: if chon=1, apply saturation and clamp, then write back:
    - If signEqu and x'[DW-1] != data[3], x' wraps. Saturate to -2^(DW-1) when data[3]=1, else to 2^(DW-1)-1.
    - Clamp step' to [STEP_MIN, STEP_MAX].
    - Write back x[ch], step[ch].
    - Register pcm = saturated x, out_ch = ch, out_valid = 1.
  - S5 with chon=0: write back x=0, step=STEP_MIN; pcm=0, out_valid=1.
- Latency: the result appears 5 cen cycles after accept.
- When cen=0: everything holds, including out_valid.
- out_valid is 1 only on the cen cycle following an S5 completion.
- Write-back and a new accept of the same channel cannot coincide, because busy is still set on that edge. The next accept reads the updated state.
- Non-targeted channels never change state.
- Reset mid-operation: in-flight results are discarded and all state returns to reset values.

Decomposition:
- Package jt10_adpcm_pkg holds:
  - the step multiplier table (57, 77, 102, 128, 153) as a constant function;
  - SW=15;
  - default STEP_MIN and STEP_MAX.
- One natural sub-module, jt10_adpcm_mch_ram: NCH-entry register file for {x, step} with a single read port (S1) and a single write port (S5), plus the async reset.
- The pipeline and busy logic live in the top module.

Test Plan:
- After reset, ch0: kon=1, chon=1, data=0x7 -> 5 cycles later pcm=238, out_ch=0, and step becomes 303 (15*127>>3=238; 153*127>>6=303).
- ch0 next nibble data=0x8 (after the 0x7) -> pcm=238-(303>>3)=201; step 57*303>>6=269.
- ch1 data=0x8 from reset -> pcm=-15; step 113 clamps to 127.
- ch3 data=0x7 repeated 60 times -> pcm climbs to 32767 and holds; step saturates at 24576. Then data=0xF repeatedly -> pcm reaches -32768 and holds.
- in_valid on ch2 for 6 consecutive cen cycles -> in_ready low for 4 cycles after accept, second accept on the 6th cycle. ch0..ch5 round-robin at 1/cycle -> accepted every cycle with tags in order.
- After ch4 has state, nibble with chon=0 -> pcm=0, and the next nibble decodes as from reset. kon=1 mid-stream -> same as from reset. in_ch=7 with NCH=6 -> in_ready=0. Assert rst_n with 3 samples in flight -> no out_valid afterwards, state at reset values.
